alu_issue_ctrl: RTL and testbench

Issue-side controller for the datapath ALU. It accepts ALU requests from the decode stage over a valid/ready handshake and translates ALUOp/funct into the 4-bit ALU control code. It drives registered operands into the ALU, waits the operation-dependent settle time, and captures result and status. The captured values are returned over a valid/ready response channel, with an optional sticky status accumulator.

---
 rtl/alu_issue_ctrl.sv | 151 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - ALU issue controller: decode, operand drive, settle wait, response capture.
// Optional sticky status accumulator enabled by ALU_ISSUE_STICKY_EN.
module alu_issue_ctrl #(
  parameter int DATA_W   = 32,
  parameter int MUL_WAIT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [1:0]        i_req_aluop,
  input  logic [5:0]        i_req_funct,
  input  logic [DATA_W-1:0] i_req_op1,
  input  logic [DATA_W-1:0] i_req_op2,
  output logic [3:0]        o_alu_control,
  output logic [DATA_W-1:0] o_alu_operand_1,
  output logic [DATA_W-1:0] o_alu_operand_2,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [7:0]        i_alu_status,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_result,
  output logic [7:0]        o_rsp_status,
  output logic              o_rsp_error,
  output logic [7:0]        o_sticky_status,
  input  logic              i_sticky_clr
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        r_state;
  logic [3:0]        r_wait;
  logic [3:0]        r_alu_control;
  logic [DATA_W-1:0] r_op1;
  logic [DATA_W-1:0] r_op2;
  logic [DATA_W-1:0] r_rsp_result;
  logic [7:0]        r_rsp_status;
  logic              r_rsp_error;

  logic [3:0] w_code;
  logic       w_legal;
  logic       w_is_mul;
  logic       w_capture;

  always_comb begin
    w_code   = 4'd0;
    w_legal  = 1'b1;
    w_is_mul = 1'b0;
    case (i_req_aluop)
      2'b00: w_code = 4'd2;
      2'b01: w_code = 4'd4;
      2'b10: begin
        case (i_req_funct)
          6'b100000: w_code = 4'd2;
          6'b100010: w_code = 4'd6;
          6'b100100: w_code = 4'd0;
          6'b100101: w_code = 4'd1;
          6'b101010: w_code = 4'd7;
          6'b011000: begin
            w_code   = 4'd3;
            w_is_mul = 1'b1;
          end
          default:   w_legal = 1'b0;
        endcase
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Ready is gated by reset so decode never sees an accept while rst_n is low.
  assign o_req_ready = i_rst_n && (r_state == S_IDLE);
  assign w_capture   = (r_state == S_EXEC) && (r_wait == 4'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_wait        <= 4'd0;
      r_alu_control <= 4'd0;
      r_op1         <= '0;
      r_op2         <= '0;
      r_rsp_result  <= '0;
      r_rsp_status  <= 8'd0;
      r_rsp_error   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            if (w_legal) begin
              r_op1         <= i_req_op1;
              r_op2         <= i_req_op2;
              r_alu_control <= w_code;
              r_wait        <= w_is_mul ? 4'(MUL_WAIT) : 4'd0;
              r_state       <= S_EXEC;
            end else begin
              r_rsp_result <= '0;
              r_rsp_status <= 8'd0;
              r_rsp_error  <= 1'b1;
              r_state      <= S_RESP;
            end
          end
        end
        S_EXEC: begin
          if (r_wait != 4'd0) begin
            r_wait <= r_wait - 4'd1;
          end else begin
            r_rsp_result <= i_alu_result;
            r_rsp_status <= i_alu_status;
            r_rsp_error  <= 1'b0;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (i_rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_ISSUE_STICKY_EN
  logic [7:0] r_sticky;

  // A clear coinciding with a capture drops old bits but keeps the new ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sticky <= 8'd0;
    end else if (w_capture) begin
      r_sticky <= (i_sticky_clr ? 8'd0 : r_sticky) | i_alu_status;
    end else if (i_sticky_clr) begin
      r_sticky <= 8'd0;
    end
  end

  assign o_sticky_status = r_sticky;
`else
  logic w_unused_sticky;
  assign w_unused_sticky = i_sticky_clr ^ w_capture;
  assign o_sticky_status = 8'd0;
`endif

  assign o_alu_control   = r_alu_control;
  assign o_alu_operand_1 = r_op1;
  assign o_alu_operand_2 = r_op2;
  assign o_rsp_valid     = (r_state == S_RESP);
  assign o_rsp_result    = r_rsp_result;
  assign o_rsp_status    = r_rsp_status;
  assign o_rsp_error     = r_rsp_error;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed-vector bench for alu_issue_ctrl.
module tb_alu_issue_ctrl;

  localparam int DATA_W   = 32;
  localparam int MUL_WAIT = 2;
`ifdef ALU_ISSUE_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_aluop;
  logic [5:0]        req_funct;
  logic [DATA_W-1:0] req_op1, req_op2;
  logic [3:0]        alu_control;
  logic [DATA_W-1:0] alu_operand_1, alu_operand_2;
  logic [DATA_W-1:0] alu_result;
  logic [7:0]        alu_status;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic [7:0]        rsp_status;
  logic              rsp_error;
  logic [7:0]        sticky_status;
  logic              sticky_clr;

  int n_checks = 0;
  int n_pass   = 0;
  int n_rsp    = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(DATA_W), .MUL_WAIT(MUL_WAIT)) u_dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_aluop     (req_aluop),
    .i_req_funct     (req_funct),
    .i_req_op1       (req_op1),
    .i_req_op2       (req_op2),
    .o_alu_control   (alu_control),
    .o_alu_operand_1 (alu_operand_1),
    .o_alu_operand_2 (alu_operand_2),
    .i_alu_result    (alu_result),
    .i_alu_status    (alu_status),
    .o_rsp_valid     (rsp_valid),
    .i_rsp_ready     (rsp_ready),
    .o_rsp_result    (rsp_result),
    .o_rsp_status    (rsp_status),
    .o_rsp_error     (rsp_error),
    .o_sticky_status (sticky_status),
    .i_sticky_clr    (sticky_clr)
  );

  // Behavioural ALU: zero flag on result, negative flag from the subtract used by compare/slt.
  logic [DATA_W-1:0] alu_diff;
  logic              alu_neg;
  always_comb begin
    alu_diff = alu_operand_1 - alu_operand_2;
    case (alu_control)
      4'd0:    alu_result = alu_operand_1 & alu_operand_2;
      4'd1:    alu_result = alu_operand_1 | alu_operand_2;
      4'd2:    alu_result = alu_operand_1 + alu_operand_2;
      4'd3:    alu_result = alu_operand_1 * alu_operand_2;
      4'd4,
      4'd6:    alu_result = alu_diff;
      4'd7:    alu_result = {{(DATA_W-1){1'b0}}, ($signed(alu_operand_1) < $signed(alu_operand_2))};
      default: alu_result = '0;
    endcase
    alu_neg    = (alu_control == 4'd7) ? alu_diff[DATA_W-1] : alu_result[DATA_W-1];
    alu_status = {(alu_result == '0), 1'b0, 1'b0, alu_neg, 4'b0000};
  end

  always @(posedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) n_rsp++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic do_req(input string tag, input logic [1:0] aluop, input logic [5:0] funct,
                        input logic [31:0] a, input logic [31:0] b, input logic clr,
                        input int exp_lat, input logic [3:0] exp_code, input logic exp_err,
                        input logic [31:0] exp_res, input logic [7:0] exp_st);
    int lat;
    @(negedge clk);
    check({tag, ".req_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_aluop = aluop;
    req_funct = funct;
    req_op1   = a;
    req_op2   = b;
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    sticky_clr = clr;
    if (!exp_err) begin
      check({tag, ".alu_control"}, 64'(alu_control), 64'(exp_code));
      check({tag, ".operand_1"}, 64'(alu_operand_1), 64'(a));
      check({tag, ".operand_2"}, 64'(alu_operand_2), 64'(b));
    end
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      sticky_clr = 1'b0;
      lat++;
    end
    sticky_clr = 1'b0;
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".rsp_error"}, 64'(rsp_error), 64'(exp_err));
    check({tag, ".rsp_result"}, 64'(rsp_result), 64'(exp_res));
    check({tag, ".rsp_status"}, 64'(rsp_status), 64'(exp_st));
  endtask

  task automatic rsp_accept(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, ".rsp_valid_drop"}, 64'(rsp_valid), 64'd0);
    check({tag, ".req_ready_back"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b1;
    req_aluop  = 2'b10;
    req_funct  = 6'b100000;
    req_op1    = 32'd1;
    req_op2    = 32'd2;
    rsp_ready  = 1'b0;
    sticky_clr = 1'b0;

    repeat (3) @(negedge clk);
    check("rst.req_ready", 64'(req_ready), 64'd0);
    check("rst.rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst.alu_control", 64'(alu_control), 64'd0);
    check("rst.operands", {alu_operand_1, alu_operand_2}, 64'd0);
    check("rst.rsp_fields", {23'd0, rsp_error, rsp_status, rsp_result}, 64'd0);
    check("rst.sticky", 64'(sticky_status), 64'd0);
    rst_n     = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst.release_ready", 64'(req_ready), 64'd1);

    do_req("add", 2'b10, 6'b100000, 32'd5, 32'd7, 1'b0, 1, 4'd2, 1'b0, 32'd12, 8'h00);
    rsp_accept("add");
    do_req("mul", 2'b10, 6'b011000, 32'd3, 32'd4, 1'b0, 1 + MUL_WAIT, 4'd3, 1'b0, 32'd12, 8'h00);
    rsp_accept("mul");
    do_req("ill", 2'b10, 6'b000111, 32'd9, 32'd9, 1'b0, 0, 4'd0, 1'b1, 32'd0, 8'h00);
    check("ill.alu_control_kept", 64'(alu_control), 64'd3);
    check("ill.operands_kept", {alu_operand_1, alu_operand_2}, {32'd3, 32'd4});
    rsp_accept("ill");
    do_req("aluop00", 2'b00, 6'b000000, 32'd100, 32'd23, 1'b0, 1, 4'd2, 1'b0, 32'd123, 8'h00);
    rsp_accept("aluop00");
    do_req("aluop01", 2'b01, 6'b000000, 32'd9, 32'd9, 1'b0, 1, 4'd4, 1'b0, 32'd0, 8'h80);
    rsp_accept("aluop01");
    do_req("aluop11", 2'b11, 6'b100000, 32'd1, 32'd1, 1'b0, 0, 4'd0, 1'b1, 32'd0, 8'h00);
    rsp_accept("aluop11");

    do_req("bp", 2'b10, 6'b100000, 32'd10, 32'd20, 1'b0, 1, 4'd2, 1'b0, 32'd30, 8'h00);
    req_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp.rsp_valid_held", 64'(rsp_valid), 64'd1);
      check("bp.rsp_result_held", 64'(rsp_result), 64'd30);
      check("bp.req_ready_low", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check("bp.rsp_valid_drop", 64'(rsp_valid), 64'd0);
    check("bp.response_count", 64'(n_rsp), 64'd7);

    // Abort a multiply mid-flight; nothing must come out afterwards.
    @(negedge clk);
    req_valid = 1'b1;
    req_aluop = 2'b10;
    req_funct = 6'b011000;
    req_op1   = 32'd6;
    req_op2   = 32'd7;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    check("abort.alu_control", 64'(alu_control), 64'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort.no_rsp", 64'(rsp_valid), 64'd0);
    check("abort.req_ready", 64'(req_ready), 64'd1);
    check("abort.response_count", 64'(n_rsp), 64'd7);

    do_req("sub", 2'b10, 6'b100010, 32'd4, 32'd4, 1'b0, 1, 4'd6, 1'b0, 32'd0, 8'h80);
    check("sub.sticky", 64'(sticky_status), STICKY ? 64'h80 : 64'h0);
    rsp_accept("sub");
    do_req("slt", 2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 1'b0, 1, 4'd7, 1'b0, 32'd1, 8'h10);
    check("slt.sticky", 64'(sticky_status), STICKY ? 64'h90 : 64'h0);
    rsp_accept("slt");
    @(negedge clk);
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    check("clr.sticky", 64'(sticky_status), 64'h0);
    do_req("sub2", 2'b10, 6'b100010, 32'd4, 32'd4, 1'b0, 1, 4'd6, 1'b0, 32'd0, 8'h80);
    check("sub2.sticky", 64'(sticky_status), STICKY ? 64'h80 : 64'h0);
    rsp_accept("sub2");
    do_req("slt_clr", 2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 1'b1, 1, 4'd7, 1'b0, 32'd1, 8'h10);
    check("slt_clr.sticky", 64'(sticky_status), STICKY ? 64'h10 : 64'h0);
    rsp_accept("slt_clr");
    do_req("ill2", 2'b10, 6'b111111, 32'd0, 32'd0, 1'b0, 0, 4'd0, 1'b1, 32'd0, 8'h00);
    check("ill2.sticky", 64'(sticky_status), STICKY ? 64'h10 : 64'h0);
    rsp_accept("ill2");
    check("end.response_count", 64'(n_rsp), 64'd12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
